// File: rtl/alu_md_pkg.sv
// Opcodes and FSM state type shared by the sequential ALU and its mul/div iterator.
package alu_md_pkg;
   localparam logic [3:0] ALU_AND   = 4'b0000;
   localparam logic [3:0] ALU_OR    = 4'b0001;
   localparam logic [3:0] ALU_ADD   = 4'b0010;
   localparam logic [3:0] ALU_SLTU  = 4'b0011;
   localparam logic [3:0] ALU_XOR   = 4'b0100;
   localparam logic [3:0] ALU_SUB   = 4'b0110;
   localparam logic [3:0] ALU_SLT   = 4'b0111;
   localparam logic [3:0] ALU_PASSB = 4'b1000;
   localparam logic [3:0] ALU_MULT  = 4'b1001;
   localparam logic [3:0] ALU_MULTU = 4'b1010;
   localparam logic [3:0] ALU_DIV   = 4'b1011;
   localparam logic [3:0] ALU_NOR   = 4'b1100;
   localparam logic [3:0] ALU_DIVU  = 4'b1101;
   localparam logic [3:0] ALU_MFHI  = 4'b1110;
   localparam logic [3:0] ALU_MFLO  = 4'b1111;

   typedef enum logic [1:0] {IDLE, RUN, FIX} md_state_t;
endpackage

// File: rtl/md_iter.sv
// Iterative shift-add multiplier / restoring divider on operand magnitudes, with sign fixup.
module md_iter
   import alu_md_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic             step_i,
   input  logic             signed_i,
   input  logic             div_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             finish_o,
   output logic [WIDTH-1:0] hi_next_o,
   output logic [WIDTH-1:0] lo_next_o
);
   // acc_q: multiply = {partial product, multiplier}; divide = {remainder, dividend/quotient}
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   b_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               div_q, neg_a_q, neg_b_q, dz_q;

   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     msum, rsh, dsub;
   logic               qbit;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   q_fix, r_fix;

   always_comb begin
      a_neg = signed_i & a_i[WIDTH-1];
      b_neg = signed_i & b_i[WIDTH-1];
      a_mag = a_neg ? -a_i : a_i;
      b_mag = b_neg ? -b_i : b_i;

      msum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, b_q & {WIDTH{acc_q[0]}}};
      rsh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      dsub  = rsh - {1'b0, b_q};
      qbit  = ~dsub[WIDTH];
      if (div_q)
         acc_d = {(qbit ? dsub[WIDTH-1:0] : rsh[WIDTH-1:0]), acc_q[WIDTH-2:0], qbit};
      else
         acc_d = {msum, acc_q[WIDTH-1:1]};

      // Remainder follows the dividend's sign; divide-by-zero forces an all-ones quotient.
      prod_fix = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
      q_fix    = dz_q ? {WIDTH{1'b1}} :
                 ((neg_a_q ^ neg_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
      r_fix    = neg_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
      hi_next_o = div_q ? r_fix : prod_fix[2*WIDTH-1:WIDTH];
      lo_next_o = div_q ? q_fix : prod_fix[WIDTH-1:0];
      finish_o  = (cnt_q == CNT_W'(WIDTH-1));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q   <= '0;
         b_q     <= '0;
         cnt_q   <= '0;
         div_q   <= 1'b0;
         neg_a_q <= 1'b0;
         neg_b_q <= 1'b0;
         dz_q    <= 1'b0;
      end else if (load_i) begin
         acc_q   <= {{WIDTH{1'b0}}, a_mag};
         b_q     <= b_mag;
         cnt_q   <= '0;
         div_q   <= div_i;
         neg_a_q <= a_neg;
         neg_b_q <= b_neg;
         dz_q    <= div_i & (b_i == '0);
      end else if (step_i) begin
         acc_q <= acc_d;
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end
endmodule

// File: rtl/alu_md_seq.sv
// Registered ALU with iterative mul/div and HI/LO registers; one op per start, result on done.
module alu_md_seq
   import alu_md_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       alu_cont,
   input  logic [WIDTH-1:0] op1,
   input  logic [WIDTH-1:0] op2,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] alu_result,
   output logic             z,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   md_state_t        state_q, state_d;
   logic [WIDTH-1:0] res_q, hi_q, lo_q, simple_res, hi_next, lo_next;
   logic             z_q, done_q, is_md, finish;
   logic             accept_simple, load_md, step_md, fix_md;

   assign is_md = (alu_cont == ALU_MULT) || (alu_cont == ALU_MULTU) ||
                  (alu_cont == ALU_DIV)  || (alu_cont == ALU_DIVU);

   always_comb begin
      simple_res = '0;
      case (alu_cont)
         ALU_ADD:   simple_res = op1 + op2;
         ALU_SUB:   simple_res = op1 - op2;
         ALU_AND:   simple_res = op1 & op2;
         ALU_OR:    simple_res = op1 | op2;
         ALU_PASSB: simple_res = op2;
         ALU_SLT:   simple_res = {{(WIDTH-1){1'b0}}, $signed(op1) < $signed(op2)};
         ALU_SLTU:  simple_res = {{(WIDTH-1){1'b0}}, op1 < op2};
         ALU_NOR:   simple_res = ~(op1 | op2);
         ALU_XOR:   simple_res = op1 ^ op2;
         ALU_MFHI:  simple_res = hi_q;
         ALU_MFLO:  simple_res = lo_q;
         default:   simple_res = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start && is_md) state_d = RUN;
         RUN:     if (finish) state_d = FIX;
         FIX:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ready         = (state_q == IDLE);
      accept_simple = ready & start & ~is_md;
      load_md       = ready & start & is_md;
      step_md       = (state_q == RUN);
      fix_md        = (state_q == FIX);
   end

   md_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_md_iter (
      .clk       (clk),
      .reset     (reset),
      .load_i    (load_md),
      .step_i    (step_md),
      .signed_i  ((alu_cont == ALU_MULT) || (alu_cont == ALU_DIV)),
      .div_i     ((alu_cont == ALU_DIV) || (alu_cont == ALU_DIVU)),
      .a_i       (op1),
      .b_i       (op2),
      .finish_o  (finish),
      .hi_next_o (hi_next),
      .lo_next_o (lo_next)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         res_q  <= '0;
         z_q    <= 1'b1;
         done_q <= 1'b0;
         hi_q   <= '0;
         lo_q   <= '0;
      end else begin
         done_q <= 1'b0;
         if (accept_simple) begin
            res_q  <= simple_res;
            z_q    <= (simple_res == '0);
            done_q <= 1'b1;
         end else if (fix_md) begin
            hi_q   <= hi_next;
            lo_q   <= lo_next;
            res_q  <= lo_next;
            z_q    <= (lo_next == '0);
            done_q <= 1'b1;
         end
      end
   end

   assign done       = done_q;
   assign alu_result = res_q;
   assign z          = z_q;
   assign hi         = hi_q;
   assign lo         = lo_q;
endmodule

// File: tb/tb_alu_md_seq.sv
// Directed-vector bench for alu_md_seq with hand-computed expected values.
module tb_alu_md_seq;
   import alu_md_pkg::*;

   logic        clk = 1'b0;
   logic        reset, start;
   logic [3:0]  alu_cont;
   logic [31:0] op1, op2;
   logic        ready, done, z;
   logic [31:0] alu_result, hi, lo;
   int          tests = 0;
   int          fails = 0;
   int          lat, rlow;

   always #5 clk = ~clk;

   alu_md_seq #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .start(start), .alu_cont(alu_cont),
      .op1(op1), .op2(op2), .ready(ready), .done(done),
      .alu_result(alu_result), .z(z), .hi(hi), .lo(lo)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive one start pulse; returns at the negedge after the sampling edge.
   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      alu_cont = op; op1 = a; op2 = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(output int n, output int nlow);
      n = 0; nlow = 0;
      while (!done && n < 100) begin
         if (!ready) nlow++;
         @(negedge clk);
         n++;
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; alu_cont = 4'b0; op1 = '0; op2 = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("rst_ready", {31'b0, ready}, 32'd1);
      check("rst_done",  {31'b0, done},  32'd0);
      check("rst_res",   alu_result,     32'd0);
      check("rst_z",     {31'b0, z},     32'd1);
      check("rst_hi",    hi,             32'd0);
      check("rst_lo",    lo,             32'd0);

      issue(ALU_ADD, 32'd5, 32'd7);
      check("add_done",  {31'b0, done},  32'd1);
      check("add_res",   alu_result,     32'd12);
      check("add_z",     {31'b0, z},     32'd0);
      check("add_ready", {31'b0, ready}, 32'd1);
      @(negedge clk);
      check("add_done_drop", {31'b0, done}, 32'd0);
      check("add_hold",  alu_result,     32'd12);

      issue(ALU_SUB, 32'd7, 32'd7);
      check("sub_res", alu_result, 32'd0);
      check("sub_z",   {31'b0, z}, 32'd1);
      issue(ALU_SLT, 32'h8000_0000, 32'd1);
      check("slt_neg", alu_result, 32'd1);
      issue(ALU_SLTU, 32'h8000_0000, 32'd1);
      check("sltu", alu_result, 32'd0);
      issue(ALU_SLT, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
      check("slt_ovf", alu_result, 32'd0);
      issue(ALU_NOR, 32'hF0F0_0000, 32'h0000_00FF);
      check("nor", alu_result, 32'h0F0F_FF00);
      issue(4'b0101, 32'd3, 32'd4);
      check("bad_op_done", {31'b0, done}, 32'd1);
      check("bad_op_res",  alu_result,     32'd0);
      check("simple_no_hi", hi, 32'd0);

      issue(ALU_MULT, 32'hFFFF_FFFD, 32'd5);
      wait_done(lat, rlow);
      check("mult_lat",   lat,  32'd33);
      check("mult_rlow",  rlow, 32'd33);
      check("mult_hi",    hi,   32'hFFFF_FFFF);
      check("mult_lo",    lo,   32'hFFFF_FFF1);
      check("mult_res",   alu_result, 32'hFFFF_FFF1);
      issue(ALU_MFLO, 32'd0, 32'd0);
      check("mflo", alu_result, 32'hFFFF_FFF1);
      issue(ALU_MFHI, 32'd0, 32'd0);
      check("mfhi", alu_result, 32'hFFFF_FFFF);

      issue(ALU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done(lat, rlow);
      check("multu_hi", hi, 32'hFFFF_FFFE);
      check("multu_lo", lo, 32'h0000_0001);

      issue(ALU_DIV, 32'hFFFF_FFF9, 32'd2);
      wait_done(lat, rlow);
      check("div_lat", lat, 32'd33);
      check("div_lo",  lo,  32'hFFFF_FFFD);
      check("div_hi",  hi,  32'hFFFF_FFFF);

      issue(ALU_DIVU, 32'd9, 32'd0);
      wait_done(lat, rlow);
      check("divu0_lat", lat, 32'd33);
      check("divu0_lo",  lo,  32'hFFFF_FFFF);
      check("divu0_hi",  hi,  32'd9);

      issue(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done(lat, rlow);
      check("divmin_lo", lo, 32'h8000_0000);
      check("divmin_hi", hi, 32'd0);
      check("divmin_z",  {31'b0, z}, 32'd0);

      // start with add during RUN must neither cut the iteration short nor produce a result
      issue(ALU_DIVU, 32'd100, 32'd7);
      repeat (4) @(negedge clk);
      alu_cont = ALU_ADD; op1 = 32'd1; op2 = 32'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("ign_no_done", {31'b0, done}, 32'd0);
      wait_done(lat, rlow);
      check("ign_lat", lat, 32'd28);
      check("ign_lo",  lo,  32'd14);
      check("ign_hi",  hi,  32'd2);

      issue(ALU_DIVU, 32'd50, 32'd3);
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_ready", {31'b0, ready}, 32'd1);
      check("abort_hi", hi, 32'd0);
      check("abort_lo", lo, 32'd0);
      check("abort_done", {31'b0, done}, 32'd0);

      issue(ALU_MULTU, 32'd6, 32'd7);
      wait_done(lat, rlow);
      check("b2b_mul_lo", lo, 32'd42);
      alu_cont = ALU_ADD; op1 = 32'd2; op2 = 32'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("b2b_done", {31'b0, done}, 32'd1);
      check("b2b_res",  alu_result,    32'd5);
      check("b2b_lo_kept", lo, 32'd42);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
